// File: rtl/window_line_buffer9.sv
// 9x9 sliding-window builder over a raster pixel stream.
// Eight column-addressed line memories feed the right edge of a register window.
module window_line_buffer9 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int PIX_W = 7,
    parameter int K     = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   sof,
    output logic [K*K*PIX_W-1:0]   win_data,
    output logic                   win_valid,
    output logic [7:0]             win_row,
    output logic [7:0]             win_col,
    output logic                   frame_done
);

    localparam int L  = K - 1;
    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [7:0] LAST_C = 8'(IMG_W - 1);
    localparam logic [7:0] LAST_R = 8'(IMG_H - 1);
    localparam logic [7:0] KM1    = 8'(K - 1);

    logic [7:0]       col;
    logic [7:0]       row;
    logic [7:0]       c;
    logic [7:0]       r;
    logic [AW-1:0]    addr;
    logic             last_c;
    logic             last_r;
    logic             hit;

    logic [PIX_W-1:0] mem     [L][IMG_W];
    logic [PIX_W-1:0] win     [K][K];
    logic [PIX_W-1:0] win_nxt [K][K];
    logic [K*K*PIX_W-1:0] flat_nxt;

    // sof forces the current pixel to the frame origin
    assign c      = sof ? 8'd0 : col;
    assign r      = sof ? 8'd0 : row;
    assign addr   = c[AW-1:0];
    assign last_c = (c == LAST_C);
    assign last_r = (r == LAST_R);
    assign hit    = (r >= KM1) && (c >= KM1);

    always_comb begin
        flat_nxt = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) begin
                win_nxt[i][j] = win[i][j+1];
            end
        end
        // row i of the window is image row r-(K-1-i); memory m holds row r-1-m
        for (int i = 0; i < L; i++) begin
            win_nxt[i][K-1] = mem[L-1-i][addr];
        end
        win_nxt[K-1][K-1] = pix_data;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                flat_nxt[PIX_W*(i*K+j) +: PIX_W] = win_nxt[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pix_valid) begin
            mem[0][addr] <= pix_data;
            for (int m = 1; m < L; m++) begin
                mem[m][addr] <= mem[m-1][addr];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= 8'd0;
            row        <= 8'd0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_data   <= '0;
            win_row    <= 8'd0;
            win_col    <= 8'd0;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                win <= win_nxt;
                if (last_c) begin
                    col <= 8'd0;
                    row <= last_r ? 8'd0 : r + 8'd1;
                end else begin
                    col <= c + 8'd1;
                    row <= r;
                end
                if (hit) begin
                    win_valid <= 1'b1;
                    win_data  <= flat_nxt;
                    win_row   <= r - KM1;
                    win_col   <= c - KM1;
                end
                frame_done <= last_c && last_r;
            end
        end
    end

endmodule

// File: doc/window_line_buffer9.md
Name: window_line_buffer9

Overview:
- Streams raster-order pixels, one per accepted cycle, from the image source.
- Builds the 9x9 sliding pixel window consumed by the innerproduct logistic-regression units.
- Keeps 8 line memories plus a 9x9 register window.
- Presents each complete window as a flattened bus with a one-cycle valid strobe, so the combinational inner-product stages can score every window position.

Parameters:
- IMG_W, 28, pixels per image row (must be >= K).
- IMG_H, 28, rows per frame (must be >= K).
- PIX_W, 7, bits per pixel.
- K, 9, window side; the window holds K*K = 81 elements.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pix_valid  in  1  pix_data is accepted on this cycle's rising edge.
- pix_data  in  PIX_W  pixel value, unsigned.
- sof  in  1  qualified by pix_valid; marks this pixel as (row 0, col 0) of a new frame.
- win_data  out  K*K*PIX_W (567)  flattened window; element k occupies bits [PIX_W*k+PIX_W-1 : PIX_W*k].
- win_valid  out  1  one-cycle strobe; win_data holds a complete window.
- win_row  out  8  image row of the window's top-left pixel.
- win_col  out  8  image column of the window's top-left pixel.
- frame_done  out  1  one-cycle strobe after the last pixel of a frame is accepted.

Behaviour:
- Reset (asynchronous, active-high) clears:
  - the col and row counters to 0;
  - all window registers, win_data, win_row and win_col to 0;
  - win_valid and frame_done to 0.
- Line-memory contents are not cleared. Validity gating guarantees they are never exposed before being written.
- A pixel is accepted when pix_valid=1 on a rising edge. When pix_valid=0, all state holds and both strobes are 0.
- Counters, for each accepted pixel:
  - The pixel's position (r, c) is the current (row, col), or (0, 0) if sof=1.
  - After acceptance, col = c+1. If c = IMG_W-1, col wraps to 0 and row = r+1. If r = IMG_H-1, row also wraps to 0.
- Line memories:
  - 8 memories, each IMG_W deep, indexed by column.
  - An accepted pixel at column c shifts the column: memory 7 <- memory 6 <- ... <- memory 0 <- pix_data, all at address c.
  - Before the shift, the memories supply the rows r-1 .. r-8 at column c.
- Window:
  - Each accepted pixel shifts the 9x9 register window left by one column.
  - The new rightmost column is filled from the memories plus pix_data.
  - Element indexing: k = i*K + j, where i=0 is the oldest row (r-8) and j=0 is the oldest column (c-8).
  - Element 0 is the top-left pixel and element 80 is the just-accepted pixel.
- Validity and timing:
  - win_valid=1 on the cycle after acceptance of (r, c) exactly when r >= 8 and c >= 8. Latency is one clock.
  - With that strobe: win_row = r-8, win_col = c-8, and win_data holds pixels (r-8 .. r, c-8 .. c).
  - win_data, win_row and win_col hold their values until the next valid window.
  - Windows never straddle a row boundary: at c = 8 the column shift has already replaced all nine columns with the current row's data.
- Windows per frame: (IMG_H-8)*(IMG_W-8), which is 400 at the defaults.
- frame_done=1 on the cycle after acceptance of (IMG_H-1, IMG_W-1). It coincides with win_valid for the last window.
- sof mid-frame:
  - The pixel is treated as (0, 0).
  - No window is produced until the new frame reaches (8, 8).
  - No frame_done is issued for the abandoned frame.
- Reset mid-frame: the next accepted pixel is (0, 0), with or without sof.
- Arithmetic: pixels pass through unmodified. The counters are sized for IMG_W and IMG_H up to 256.

Test Plan:
- Ramp frame, 28x28: pixel(r, c) = (28r+c) mod 128, pix_valid held at 1, sof on the first pixel.
  - First win_valid one cycle after pixel (8, 8), with win_row=0, win_col=0.
  - Element 0 = 0, element 8 = 8, element 72 = 224 mod 128 = 96, element 80 = 232 mod 128 = 104.
  - Exactly 400 win_valid strobes, then frame_done one cycle after pixel (27, 27).
- Row transition, same ramp frame:
  - No win_valid for pixels with c < 8 in rows r >= 8.
  - The window at win_row=5, win_col=19 has element 0 = 159 mod 128 = 31 and element 80 = (28*13+27) mod 128 = 391 mod 128 = 7.
- Gapped input: pix_valid random at 50%.
  - The window sequence is identical to the first scenario.
  - win_valid and frame_done never assert on cycles that do not follow an accepted pixel.
- sof mid-frame: sof at row 12, col 3.
  - That pixel becomes (0, 0).
  - The next win_valid follows the 9th pixel of the 9th new row.
  - No frame_done for the aborted frame.
- Asynchronous reset mid-frame, asserted between clock edges at row 10:
  - All outputs go to 0 immediately.
  - After release, a full frame without sof yields 400 windows with correct contents.
- Back-to-back frames, two ramp frames with no gap:
  - 800 windows and 2 frame_done strobes.
  - The first window of frame 2 contains only frame-2 data.
